// File: rtl/pipe_retire_tracker.sv
// pipe_retire_tracker: shadow pipeline that follows fetched instructions to write-back,
// checks retire strobes against it and queues every retirement in a trace FIFO.
module pipe_retire_tracker #(
  parameter int          STAGES     = 4,
  parameter int          XLEN       = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] END_INSTR  = 32'h0000000c
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid_i,
  input  logic [XLEN-1:0]   fetch_pc_i,
  input  logic [31:0]       fetch_instr_i,
  input  logic [1:0]        fetch_type_i,
  input  logic [STAGES-1:0] stall_i,
  input  logic [STAGES-1:0] flush_i,
  input  logic              retire_i,
  input  logic              trc_ready_i,
  output logic              trc_valid_o,
  output logic [XLEN-1:0]   trc_pc_o,
  output logic [31:0]       trc_instr_o,
  output logic [1:0]        trc_type_o,
  output logic [CNT_W-1:0]  trc_seq_o,
  output logic [CNT_W-1:0]  retired_cnt_o,
  output logic              overflow_o,
  output logic              sync_err_o,
  output logic              end_seen_o
);
  localparam int L  = STAGES - 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = XLEN + 32 + 2 + CNT_W;

  logic [STAGES-1:0] v_q, v_d, hold, in_v, ld, clr;
  logic [XLEN-1:0]   pc_q    [STAGES];
  logic [31:0]       instr_q [STAGES];
  logic [1:0]        type_q  [STAGES];
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q, err_q, end_q;
  logic [AW:0]       wr_q, rd_q;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic              push, err, full, pop, wr_en;

  // A stalled stage freezes everything younger than it as well.
  genvar g;
  for (g = 0; g < STAGES; g++) begin : g_hold
    assign hold[g] = |stall_i[L:g];
  end

  // Retiring out of a held write-back stage empties it rather than holding it.
  always_comb begin
    in_v[0] = fetch_valid_i;
    for (int i = 1; i < STAGES; i++) in_v[i] = v_q[i-1] & ~hold[i-1];
    clr = {retire_i, {L{1'b0}}};
    ld  = ~hold & ~flush_i;
    v_d = ~flush_i & ((hold & v_q & ~clr) | (~hold & in_v));
  end

  assign push  = retire_i & v_q[L];
  assign err   = retire_i ? ~v_q[L] : v_q[L] & ~hold[L] & ~flush_i[L];
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign trc_valid_o = wr_q != rd_q;
  assign pop   = trc_valid_o & trc_ready_i;
  assign wr_en = push & (~full | pop);
  assign {trc_pc_o, trc_instr_o, trc_type_o, trc_seq_o} = trc_valid_o ? mem_q[rd_q[AW-1:0]] : '0;
  assign retired_cnt_o = cnt_q;
  assign overflow_o    = ovf_q;
  assign sync_err_o    = err_q;
  assign end_seen_o    = end_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
        type_q[i]  <= '0;
      end
      cnt_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      end_q <= 1'b0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      v_q <= v_d;
      if (ld[0]) begin
        pc_q[0]    <= fetch_pc_i;
        instr_q[0] <= fetch_instr_i;
        type_q[0]  <= fetch_type_i;
      end
      for (int i = 1; i < STAGES; i++)
        if (ld[i]) begin
          pc_q[i]    <= pc_q[i-1];
          instr_q[i] <= instr_q[i-1];
          type_q[i]  <= type_q[i-1];
        end
      wr_q  <= wr_q + (AW+1)'(wr_en);
      rd_q  <= rd_q + (AW+1)'(pop);
      cnt_q <= cnt_q + CNT_W'(push);
      ovf_q <= ovf_q | (push & ~wr_en);
      err_q <= err_q | err;
      end_q <= end_q | (push && instr_q[L] == END_INSTR);
    end

  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q[AW-1:0]] <= {pc_q[L], instr_q[L], type_q[L], cnt_q};
endmodule

// File: tb/tb_pipe_retire_tracker.sv
// tb_pipe_retire_tracker: randomized scoreboard bench; a queue-based model predicts the trace
// stream and status flags, and a negedge monitor compares and pops.
module tb_pipe_retire_tracker;
  localparam int S = 4;
  localparam int D = 8;
  localparam int L = S - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_valid = 1'b0;
  logic [31:0]   fetch_pc = '0;
  logic [31:0]   fetch_instr = '0;
  logic [1:0]    fetch_type = '0;
  logic [S-1:0]  stall = '0;
  logic [S-1:0]  flush = '0;
  logic          retire = 1'b0;
  logic          trc_ready = 1'b0;
  logic          trc_valid, overflow, sync_err, end_seen;
  logic [31:0]   trc_pc, trc_instr, trc_seq, retired_cnt;
  logic [1:0]    trc_type;

  pipe_retire_tracker #(.STAGES(S), .XLEN(32), .FIFO_DEPTH(D), .CNT_W(32),
                        .END_INSTR(32'h0000000c)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid_i(fetch_valid), .fetch_pc_i(fetch_pc), .fetch_instr_i(fetch_instr),
    .fetch_type_i(fetch_type), .stall_i(stall), .flush_i(flush), .retire_i(retire),
    .trc_ready_i(trc_ready), .trc_valid_o(trc_valid), .trc_pc_o(trc_pc),
    .trc_instr_o(trc_instr), .trc_type_o(trc_type), .trc_seq_o(trc_seq),
    .retired_cnt_o(retired_cnt), .overflow_o(overflow), .sync_err_o(sync_err),
    .end_seen_o(end_seen)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; logic [31:0] pc; logic [31:0] instr; logic [1:0] t;} slot_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic [1:0] t; logic [31:0] seq;} ent_t;

  slot_t       pipe [S];
  ent_t        q [$];
  logic [31:0] m_cnt;
  bit          m_ovf, m_err, m_end;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < S; i++) pipe[i] = '{v: 1'b0, pc: '0, instr: '0, t: '0};
    q.delete();
    m_cnt = '0;
    m_ovf = 0;
    m_err = 0;
    m_end = 0;
  endfunction

  // Frozen prefix up to the oldest stalled stage k, a bubble just behind it, the rest shifts.
  function automatic void model_step();
    slot_t nx [S];
    int k = -1;
    for (int i = 0; i < S; i++) if (stall[i]) k = i;
    if (retire && pipe[L].v) begin
      if (q.size() < D) q.push_back('{pc: pipe[L].pc, instr: pipe[L].instr, t: pipe[L].t, seq: m_cnt});
      else m_ovf = 1;
      if (pipe[L].instr == 32'h0000000c) m_end = 1;
      m_cnt++;
    end else if (retire || (pipe[L].v && k < L && !flush[L])) m_err = 1;
    for (int i = 0; i < S; i++) begin
      if (i <= k) nx[i] = pipe[i];
      else if (i == 0) nx[i] = '{v: fetch_valid, pc: fetch_pc, instr: fetch_instr, t: fetch_type};
      else begin
        nx[i] = pipe[i-1];
        if (i - 1 == k) nx[i].v = 1'b0;
      end
    end
    if (retire && k == L) nx[L].v = 1'b0;
    for (int i = 0; i < S; i++) if (flush[i]) nx[i].v = 1'b0;
    pipe = nx;
  endfunction

  function automatic bit ar();
    return pipe[L].v;
  endfunction

  task automatic cyc(bit fv, logic [31:0] pc, logic [31:0] ins, logic [1:0] ty,
                     logic [S-1:0] st, logic [S-1:0] fl, bit ret, bit rdy);
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = ins;
    fetch_type  = ty;
    stall       = st;
    flush       = fl;
    retire      = ret;
    trc_ready   = rdy;
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic idle(int n, bit rdy);
    repeat (n) cyc(0, '0, '0, '0, '0, '0, ar(), rdy);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, " trc_valid"}, 32'(trc_valid), 32'd0);
    chk({tag, " trc_pc"}, trc_pc, 32'd0);
    chk({tag, " trc_instr"}, trc_instr, 32'd0);
    chk({tag, " trc_type"}, 32'(trc_type), 32'd0);
    chk({tag, " trc_seq"}, trc_seq, 32'd0);
    chk({tag, " retired_cnt"}, retired_cnt, 32'd0);
    chk({tag, " flags"}, {29'd0, overflow, sync_err, end_seen}, 32'd0);
  endtask

  always @(negedge clk) begin
    chk("trc_valid", 32'(trc_valid), 32'(q.size() != 0));
    if (q.size() != 0 && trc_valid) begin
      chk("trc_pc", trc_pc, q[0].pc);
      chk("trc_instr", trc_instr, q[0].instr);
      chk("trc_type", 32'(trc_type), 32'(q[0].t));
      chk("trc_seq", trc_seq, q[0].seq);
    end
    chk("retired_cnt", retired_cnt, m_cnt);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("end_seen", 32'(end_seen), 32'(m_end));
    if (rst_n && q.size() != 0 && trc_ready) void'(q.pop_front());
  end

  initial begin
    model_reset();
    #3 chk_reset_outputs("por");
    @(posedge clk);
    #1 rst_n = 1'b1;
    // three back-to-back instructions, no hazards
    for (int i = 0; i < 3; i++) cyc(1, 32'(4 * i), 32'h01000020 + 32'(i), 2'b01, '0, '0, ar(), 1);
    idle(6, 1);
    // stall stage 1 for two cycles mid-stream
    for (int i = 0; i < 6; i++)
      cyc(1, 32'h100 + 32'(4 * i), 32'h8c000000 + 32'(i), 2'b10,
          (i == 2 || i == 3) ? 4'b0010 : 4'b0000, '0, ar(), 1);
    idle(6, 1);
    // branch at 0x200 flushes the two younger slots, target 0x300
    cyc(1, 32'h200, 32'h10000004, 2'b10, '0, '0, ar(), 1);
    cyc(1, 32'h204, 32'h00000020, 2'b01, '0, '0, ar(), 1);
    cyc(1, 32'h208, 32'h00000021, 2'b01, '0, 4'b0011, ar(), 1);
    cyc(1, 32'h300, 32'h08000000, 2'b11, '0, '0, ar(), 1);
    idle(6, 1);
    // random hazards with a well-behaved retire strobe
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom), {$urandom_range(0, 1023), 2'b00}, $urandom, 2'($urandom),
          ($urandom % 4 == 0) ? S'($urandom) : '0, ($urandom % 8 == 0) ? S'($urandom) : '0,
          ar(), $urandom % 4 != 0);
    idle(20, 1);
    // consumer stalled: ten retirements into an eight-deep FIFO
    for (int i = 0; i < 10; i++) cyc(1, 32'h400 + 32'(4 * i), 32'h20000000 + 32'(i), 2'b10, '0, '0, ar(), 0);
    idle(S + 2, 0);
    // drain while still retiring, so full+pop+push coincide
    for (int i = 0; i < 12; i++) cyc(1, 32'h500 + 32'(4 * i), 32'h24000000 + 32'(i), 2'b10, '0, '0, ar(), 1);
    idle(20, 1);
    // end-of-test syscall
    cyc(1, 32'h600, 32'h0000000c, 2'b01, '0, '0, ar(), 1);
    idle(6, 1);
    // spurious retire on an empty write-back stage, then a lazy retire strobe
    cyc(0, '0, '0, '0, '0, '0, 1, 1);
    idle(3, 1);
    for (int i = 0; i < 100; i++)
      cyc(1'($urandom), {$urandom_range(0, 1023), 2'b00}, $urandom, 2'($urandom),
          ($urandom % 4 == 0) ? S'($urandom) : '0, ($urandom % 8 == 0) ? S'($urandom) : '0,
          ($urandom % 3 == 0) ? 1'($urandom) : ar(), $urandom % 3 != 0);
    // asynchronous reset in the middle of traffic
    for (int i = 0; i < 6; i++) cyc(1, 32'h700 + 32'(4 * i), 32'h3c000000 + 32'(i), 2'b10, '0, '0, ar(), 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_reset_outputs("mid");
    fetch_valid = 1'b0;
    retire = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1, 32'h800 + 32'(4 * i), 32'h01000020, 2'b01, '0, '0, ar(), 1);
    idle(8, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_retire_tracker.md
# pipe_retire_tracker

Parametrised shadow pipeline and retirement trace buffer for the pipelined MIPS core. It follows each fetched instruction (pc, instr, format class) through STAGES pipeline stages, honouring per-stage stalls and flushes. It checks that every retire strobe lines up with a valid tracked instruction. It pushes each retirement into a FIFO drained by a valid/ready consumer (checker, trace port or DPI bridge). It is synthesisable, sits beside the core and taps only its fetch, hazard and retire signals.

## Interface
- STAGES, 4, tracked stages after fetch; stage 0 = issue, stage STAGES-1 = write-back; legal 2..8
- XLEN, 32, pc width
- FIFO_DEPTH, 8, trace entries; power of two, >= 2
- CNT_W, 32, width of sequence/retire counter
- END_INSTR, 32'h0000000c, instruction word that marks end of test (syscall)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_valid  in  1  fetch stage holds a real instruction
- fetch_pc  in  XLEN  pc of fetched instruction
- fetch_instr  in  32  fetched instruction word
- fetch_type  in  2  01 R-type, 10 I-type, 11 J-type, 00 unknown
- stall  in  STAGES  stall[i] holds stage i
- flush  in  STAGES  flush[i] kills stage i contents
- retire  in  1  core retire strobe for write-back stage
- trc_ready  in  1  consumer accepts head entry
- trc_valid  out  1  FIFO non-empty
- trc_pc  out  XLEN  head entry pc
- trc_instr  out  32  head entry instruction
- trc_type  out  2  head entry class
- trc_seq  out  CNT_W  head entry retirement sequence number (0-based)
- retired_cnt  out  CNT_W  total retirements accepted
- overflow  out  1  sticky: a retirement found FIFO full and was dropped
- sync_err  out  1  sticky: retire/pipeline mismatch
- end_seen  out  1  sticky: END_INSTR retired

## Operation
- Each stage i holds {v, pc, instr, type}. Effective hold h[i] = OR of stall[i..STAGES-1]: a stalled stage also freezes all earlier stages.
- Per edge, in priority order: flush[i] -> v[i]=0. Else h[i] -> keep. Else load from stage i-1 (stage 0 loads from fetch_*, v=fetch_valid). Where h[i-1]=1 and h[i]=0, stage i loads a bubble (v=0).
- Flush overrides stall. Flushed/bubble stages keep stale payload; only v is meaningful.
- Retire event, evaluated on the last stage L=STAGES-1 at each edge:
  - retire=1 and v[L]=1 -> retirement.
  - retire=1 and v[L]=0 -> sync_err set; nothing pushed.
  - retire=0, v[L]=1, h[L]=0, flush[L]=0 -> sync_err set; the instruction left unretired.
  - retire=1 with h[L]=1 is legal: the stage retires once, then is cleared (v[L]=0) instead of held.
- Retirement: push {pc, instr, type, retired_cnt} and increment retired_cnt (wraps at 2^CNT_W). If instr==END_INSTR, set end_seen.
- FIFO: a pop occurs when trc_valid && trc_ready. A push succeeds if not full, or if full with a pop in the same cycle. Otherwise the entry is dropped, overflow is set, and retired_cnt still increments, so trc_seq shows the gap. Simultaneous push and pop on empty: the entry is written; trc_valid rises next cycle.
- trc_* reflect the head entry and stay stable while trc_valid && !trc_ready.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous assert, synchronous release on next edge): all v=0, FIFO empty, trc_valid=0, trc_pc/trc_instr/trc_type/trc_seq=0, retired_cnt=0, overflow=sync_err=end_seen=0.
- Reset mid-operation discards all in-flight and buffered entries.
- Fetch-to-write-back: STAGES edges with no stalls. The instruction captured at edge n occupies stage L after edge n+STAGES-1, and retire is sampled at edge n+STAGES.
- Retire to trc_valid: 1 cycle (entry visible after the retiring edge).
- Pop: head advances on the accepting edge; back-to-back pops at 1 entry/cycle.
- retired_cnt, end_seen, overflow and sync_err update on the same edge as the triggering event.

## Test plan
- STAGES=4, no stalls: fetch pc 0x0,0x4,0x8 with retire asserted 4 edges after each, trc_ready=1 -> three entries in order with seq 0,1,2; retired_cnt=3; sync_err=0.
- stall[1]=1 for 2 cycles mid-stream -> stages 0-1 freeze, stage 2 receives 2 bubbles; retire held low in those cycles; order preserved; sync_err=0.
- flush[0..1]=2'b11 after a branch -> two younger instructions never retire; no sync_err; next retired pc is the branch target.
- retire=1 while v[L]=0 -> sync_err=1 next cycle; FIFO unchanged; retired_cnt unchanged.
- FIFO_DEPTH=8, trc_ready=0, 10 retirements -> 8 entries held, overflow=1, retired_cnt=10. Then ready=1 -> seq 0..7 drained; full+pop+push in the same cycle -> no drop.
- Retire instr 0x0000000c -> end_seen=1 on that edge. Reset asserted mid-run -> all outputs return to reset values asynchronously.
